fifo_multi_ch_ring: RTL and testbench
=====================================

Name: fifo_multi_ch_ring

Overview:
- Parametrised successor to the multi-channel shift-register delay line.
- Circular-buffer FIFO carrying FIFO_CH_NUM packed channels of FIFO_CH_WIDTH bits each.
- Independent write/read enables, occupancy count, full/empty/almost-full status, flush, and a registered read port with a valid flag.
- Sits between BCH decoder stages (syndrome → key-equation → Chien search) to absorb rate mismatch, where a fixed-length delay line is insufficient.

Parameters:
FIFO_DEPTH, 8, number of entries; legal range 2..1024; need not be a power of two.
FIFO_CH_WIDTH, 2, bits per channel; must be at least 1.
FIFO_CH_NUM, 4, channel count; bus width W = FIFO_CH_NUM*FIFO_CH_WIDTH.
FIFO_AFULL_TH, 6, out_sts_afull asserts when count >= this value; legal range 1..FIFO_DEPTH.
CNT_W, $clog2(FIFO_DEPTH+1), width of the occupancy count (localparam).

Ports:
clk  in  1  clock; all logic on the rising edge.
in_ctr_Srst  in  1  synchronous reset, active-high.
in_ctr_flush  in  1  synchronous flush: empties the FIFO, memory contents untouched.
in_ctr_wr_en  in  1  write request.
in  in  W  write data; channel k is bits [k*FIFO_CH_WIDTH +: FIFO_CH_WIDTH].
in_ctr_rd_en  in  1  read request.
out  out  W  registered read data.
out_vld  out  1  out holds a newly read word this cycle.
out_sts_full  out  1  count == FIFO_DEPTH.
out_sts_empty  out  1  count == 0.
out_sts_afull  out  1  count >= FIFO_AFULL_TH.
out_sts_cnt  out  CNT_W  current occupancy.

Behaviour:
- Reset is synchronous and active-high and takes priority over everything.
  - On reset: wr_ptr = 0, rd_ptr = 0, count = 0, out = 0, out_vld = 0.
  - Status after reset: empty = 1, full = 0, afull = 0.
- Flush has second priority; all wr/rd requests in a flush cycle are ignored.
  - Pointers and count go to 0 and out_vld goes to 0.
  - out holds its last value.
- Write accept: wr_acc = wr_en & (!full | rd_acc).
  - Writing while full is legal only when a read is accepted in the same cycle.
  - Otherwise the write is dropped; the FIFO is not modified.
- Read accept: rd_acc = rd_en & !empty.
  - Read while empty is ignored, including when a write occurs in the same cycle; there is no bypass.
- Accepted write: mem[wr_ptr] <= in; wr_ptr advances.
- Accepted read: out <= mem[rd_ptr] and out_vld <= 1 on the next edge; rd_ptr advances.
  - Read latency is 1 cycle from the rd_en edge.
  - out_vld is a single-cycle pulse per accepted read.
- No accepted read: out_vld <= 0 and out holds its value.
- Pointer wrap: the pointer after FIFO_DEPTH-1 is 0; explicit compare, not modulo-2^n.
- Count update:
  - +1 on wr_acc & !rd_acc.
  - -1 on rd_acc & !wr_acc.
  - Unchanged when both or neither are accepted.
- Status outputs are registered and derived from the next-state count, so they are valid in the same cycle as out_sts_cnt.
- Ordering is strict FIFO. Data written at cycle t can be read at the earliest at t+1 and appears on out at t+2.
- Every channel shares the same pointers; channels never skew relative to each other.

Optional Feature:
- Macro: FIFO_MULTI_CH_RING_ERR_EN.
- When defined, adds two ports: out_err_ovf (1) and out_err_udf (1).
  - out_err_ovf is a sticky flag, set on a dropped write (wr_en & !wr_acc & !flush).
  - out_err_udf is a sticky flag, set on a read while empty (rd_en & empty & !flush).
  - Both flags are cleared only by in_ctr_Srst; flush does not clear them.
  - Both flags go to 1 on the edge after the offending request.
- When not defined:
  - Neither port exists and no error logic is built.
  - Dropped writes and empty reads are silently ignored.

Test Plan:
- Reset then idle → empty=1, full=0, cnt=0, out=0, out_vld=0 for 10 cycles.
- DEPTH=8, 8 writes of 0x01..0x08 (W=8) → cnt steps 1..8; afull rises at the 6th write; full=1.
  - A 9th write of 0xFF is dropped: cnt stays 8; ovf=1 when ERR_EN is defined.
- Drain 8 reads → out_vld pulses carry 0x01..0x08 in order, one cycle after each rd_en; empty=1 after the 8th.
  - A 9th read gives out_vld=0; udf=1 when ERR_EN is defined.
- DEPTH=5 (non-power-of-two): continuous simultaneous wr/rd with a counter pattern for 23 cycles after priming 3 words → cnt constant at 3, no loss across pointer wrap, output sequence equals input delayed by 3 words.
- Full plus simultaneous wr/rd → write accepted, cnt stays at FIFO_DEPTH, read word is the oldest entry, new word appears after DEPTH further reads.
- Flush with 4 entries while wr_en=rd_en=1 → next cycle cnt=0, empty=1, out_vld=0, out unchanged.
  - Assert in_ctr_Srst together with in_ctr_flush and wr_en → reset values; out=0.

Source files
------------

// File: rtl/fifo_multi_ch_ring.sv
// rtl/fifo_multi_ch_ring.sv - multi-channel circular-buffer FIFO with registered read port
//
// Purpose:
//   Circular-buffer FIFO carrying FIFO_CH_NUM packed channels of FIFO_CH_WIDTH
//   bits each. All channels share one pair of pointers, so they never skew.
//   Used between BCH decoder stages to absorb rate mismatch.
//
// Optional build macro:
//   FIFO_MULTI_CH_RING_ERR_EN - adds sticky overflow/underflow flags
//                               (out_err_ovf, out_err_udf), cleared only by reset.
//
// Ports:
//   clk            clock, rising edge
//   in_ctr_Srst    synchronous reset, active-high, highest priority
//   in_ctr_flush   synchronous flush: pointers/count to 0, memory untouched
//   in_ctr_wr_en   write request
//   in             write data, channel k at [k*FIFO_CH_WIDTH +: FIFO_CH_WIDTH]
//   in_ctr_rd_en   read request
//   out            registered read data (1-cycle latency)
//   out_vld        one-cycle pulse per accepted read
//   out_sts_full   count == FIFO_DEPTH
//   out_sts_empty  count == 0
//   out_sts_afull  count >= FIFO_AFULL_TH
//   out_sts_cnt    current occupancy
//   out_err_ovf    (ERR_EN only) sticky: write dropped
//   out_err_udf    (ERR_EN only) sticky: read while empty
module fifo_multi_ch_ring #(
    parameter int FIFO_DEPTH    = 8,
    parameter int FIFO_CH_WIDTH = 2,
    parameter int FIFO_CH_NUM   = 4,
    parameter int FIFO_AFULL_TH = 6,
    localparam int W     = FIFO_CH_NUM * FIFO_CH_WIDTH,
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             in_ctr_Srst,
    input  logic             in_ctr_flush,
    input  logic             in_ctr_wr_en,
    input  logic [W-1:0]     in,
    input  logic             in_ctr_rd_en,
    output logic [W-1:0]     out,
    output logic             out_vld,
    output logic             out_sts_full,
    output logic             out_sts_empty,
    output logic             out_sts_afull,
`ifdef FIFO_MULTI_CH_RING_ERR_EN
    output logic             out_err_ovf,
    output logic             out_err_udf,
`endif
    output logic [CNT_W-1:0] out_sts_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(FIFO_AFULL_TH);

    logic [W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wr_acc;
    logic             rd_acc;
    logic             upd;

    // No read-through-write bypass: an empty FIFO ignores reads even if a
    // write lands in the same cycle.
    assign rd_acc = in_ctr_rd_en & ~out_sts_empty;
    // A write into a full FIFO is legal only when a read frees a slot this cycle.
    assign wr_acc = in_ctr_wr_en & (~out_sts_full | rd_acc);
    // Requests only take effect outside reset and flush.
    assign upd    = ~in_ctr_Srst & ~in_ctr_flush;

    // Next occupancy; status flags are registered from this so they line up
    // with out_sts_cnt in the same cycle.
    always_comb begin
        cnt_nxt = out_sts_cnt;
        if (!upd) begin
            cnt_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            cnt_nxt = out_sts_cnt + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            cnt_nxt = out_sts_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        out_sts_cnt   <= cnt_nxt;
        out_sts_full  <= (cnt_nxt == CNT_FULL);
        out_sts_empty <= (cnt_nxt == '0);
        out_sts_afull <= (cnt_nxt >= CNT_AFULL);
        if (in_ctr_Srst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            out     <= '0;
            out_vld <= 1'b0;
        end else if (in_ctr_flush) begin
            // out deliberately keeps its last value across a flush.
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                out    <= mem[rd_ptr];
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage has no reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (upd && wr_acc) begin
            mem[wr_ptr] <= in;
        end
    end

`ifdef FIFO_MULTI_CH_RING_ERR_EN
    always_ff @(posedge clk) begin
        if (in_ctr_Srst) begin
            out_err_ovf <= 1'b0;
            out_err_udf <= 1'b0;
        end else if (!in_ctr_flush) begin
            if (in_ctr_wr_en && !wr_acc) begin
                out_err_ovf <= 1'b1;
            end
            if (in_ctr_rd_en && out_sts_empty) begin
                out_err_udf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_multi_ch_ring.sv
// tb/tb_fifo_multi_ch_ring.sv - directed self-checking bench for fifo_multi_ch_ring
module tb_fifo_multi_ch_ring;

    logic       clk;
    logic       rst;
    logic       flush;

    logic       a_wr, a_rd;
    logic [7:0] a_in, a_out;
    logic       a_vld, a_full, a_empty, a_afull;
    logic [3:0] a_cnt;

    logic       b_wr, b_rd;
    logic [7:0] b_in, b_out;
    logic       b_vld, b_full, b_empty, b_afull;
    logic [2:0] b_cnt;

`ifdef FIFO_MULTI_CH_RING_ERR_EN
    logic a_ovf, a_udf, b_ovf, b_udf;
`endif

    int n_pass = 0;
    int n_chk  = 0;

    fifo_multi_ch_ring #(
        .FIFO_DEPTH(8), .FIFO_CH_WIDTH(2), .FIFO_CH_NUM(4), .FIFO_AFULL_TH(6)
    ) u_dut_a (
        .clk(clk), .in_ctr_Srst(rst), .in_ctr_flush(flush),
        .in_ctr_wr_en(a_wr), .in(a_in), .in_ctr_rd_en(a_rd),
        .out(a_out), .out_vld(a_vld),
        .out_sts_full(a_full), .out_sts_empty(a_empty), .out_sts_afull(a_afull),
`ifdef FIFO_MULTI_CH_RING_ERR_EN
        .out_err_ovf(a_ovf), .out_err_udf(a_udf),
`endif
        .out_sts_cnt(a_cnt)
    );

    fifo_multi_ch_ring #(
        .FIFO_DEPTH(5), .FIFO_CH_WIDTH(2), .FIFO_CH_NUM(4), .FIFO_AFULL_TH(4)
    ) u_dut_b (
        .clk(clk), .in_ctr_Srst(rst), .in_ctr_flush(flush),
        .in_ctr_wr_en(b_wr), .in(b_in), .in_ctr_rd_en(b_rd),
        .out(b_out), .out_vld(b_vld),
        .out_sts_full(b_full), .out_sts_empty(b_empty), .out_sts_afull(b_afull),
`ifdef FIFO_MULTI_CH_RING_ERR_EN
        .out_err_ovf(b_ovf), .out_err_udf(b_udf),
`endif
        .out_sts_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; flush = 1'b0;
        a_wr = 1'b0; a_rd = 1'b0; a_in = '0;
        b_wr = 1'b0; b_rd = 1'b0; b_in = '0;
        step();
        rst = 1'b0;

        // Reset state held over 10 idle cycles
        for (int i = 0; i < 10; i++) begin
            check("idle_empty", 32'(a_empty), 32'd1);
            check("idle_full",  32'(a_full),  32'd0);
            check("idle_cnt",   32'(a_cnt),   32'd0);
            check("idle_out",   32'(a_out),   32'd0);
            check("idle_vld",   32'(a_vld),   32'd0);
            step();
        end
        check("idle_afull", 32'(a_afull), 32'd0);
        check("b_idle_empty", 32'(b_empty), 32'd1);

        // Depth 5: prime 3 words, then 23 cycles of simultaneous wr/rd across wrap
        b_wr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b_in = 8'(k);
            step();
        end
        check("b_prime_cnt", 32'(b_cnt), 32'd3);
        b_rd = 1'b1;
        for (int k = 3; k < 26; k++) begin
            b_in = 8'(k);
            step();
            check("b_stream_cnt", 32'(b_cnt), 32'd3);
            check("b_stream_vld", 32'(b_vld), 32'd1);
            check("b_stream_out", 32'(b_out), 32'(k - 3));
        end
        b_wr = 1'b0; b_rd = 1'b0;
        step();
        check("b_stream_vld_end", 32'(b_vld), 32'd0);

        // Depth 8: fill with 0x01..0x08
        a_wr = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_in = 8'(i);
            step();
            check("fill_cnt",   32'(a_cnt),   32'(i));
            check("fill_afull", 32'(a_afull), 32'(i >= 6));
            check("fill_full",  32'(a_full),  32'(i == 8));
            check("fill_empty", 32'(a_empty), 32'd0);
        end
        // 9th write dropped
        a_in = 8'hFF;
        step();
        a_wr = 1'b0;
        check("ovf_cnt",  32'(a_cnt),  32'd8);
        check("ovf_full", 32'(a_full), 32'd1);
`ifdef FIFO_MULTI_CH_RING_ERR_EN
        check("ovf_flag", 32'(a_ovf), 32'd1);
        check("udf_flag_clear", 32'(a_udf), 32'd0);
`endif

        // Drain 8 reads, in order, one cycle latency
        a_rd = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check("drain_vld", 32'(a_vld), 32'd1);
            check("drain_out", 32'(a_out), 32'(i));
            check("drain_cnt", 32'(a_cnt), 32'(8 - i));
        end
        check("drain_empty", 32'(a_empty), 32'd1);
        check("drain_afull", 32'(a_afull), 32'd0);
        // 9th read ignored
        step();
        a_rd = 1'b0;
        check("udf_vld", 32'(a_vld), 32'd0);
        check("udf_out_hold", 32'(a_out), 32'd8);
        check("udf_cnt", 32'(a_cnt), 32'd0);
`ifdef FIFO_MULTI_CH_RING_ERR_EN
        check("udf_flag", 32'(a_udf), 32'd1);
`endif

        // Full plus simultaneous wr/rd
        a_wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_in = 8'(8'h11 + i);
            step();
        end
        check("refill_full", 32'(a_full), 32'd1);
        a_rd = 1'b1;
        a_in = 8'h99;
        step();
        a_wr = 1'b0;
        check("fullrw_out",  32'(a_out),  32'h11);
        check("fullrw_vld",  32'(a_vld),  32'd1);
        check("fullrw_cnt",  32'(a_cnt),  32'd8);
        check("fullrw_full", 32'(a_full), 32'd1);
        for (int j = 0; j < 8; j++) begin
            step();
            check("fullrw_drain", 32'(a_out), (j < 7) ? 32'(8'h12 + j) : 32'h99);
            check("fullrw_cnt2",  32'(a_cnt), 32'(7 - j));
        end
        a_rd = 1'b0;
        step();
        check("fullrw_empty", 32'(a_empty), 32'd1);

        // Flush with 4 entries while wr_en=rd_en=1
        a_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in = 8'(8'h21 + i);
            step();
        end
        check("preflush_cnt", 32'(a_cnt), 32'd4);
        flush = 1'b1; a_rd = 1'b1; a_in = 8'h77;
        step();
        flush = 1'b0; a_wr = 1'b0; a_rd = 1'b0;
        check("flush_cnt",   32'(a_cnt),   32'd0);
        check("flush_empty", 32'(a_empty), 32'd1);
        check("flush_vld",   32'(a_vld),   32'd0);
        check("flush_out",   32'(a_out),   32'h99);
`ifdef FIFO_MULTI_CH_RING_ERR_EN
        check("flush_keeps_ovf", 32'(a_ovf), 32'd1);
`endif
        // Pointers restarted: next write lands at slot 0 and reads back
        a_wr = 1'b1; a_in = 8'h55;
        step();
        a_wr = 1'b0; a_rd = 1'b1;
        step();
        a_rd = 1'b0;
        check("postflush_out", 32'(a_out), 32'h55);
        check("postflush_vld", 32'(a_vld), 32'd1);
        check("postflush_cnt", 32'(a_cnt), 32'd0);

        // Reset together with flush and write
        rst = 1'b1; flush = 1'b1; a_wr = 1'b1; a_in = 8'h66;
        step();
        rst = 1'b0; flush = 1'b0; a_wr = 1'b0;
        check("rst_cnt",   32'(a_cnt),   32'd0);
        check("rst_out",   32'(a_out),   32'd0);
        check("rst_empty", 32'(a_empty), 32'd1);
        check("rst_vld",   32'(a_vld),   32'd0);
        check("rst_full",  32'(a_full),  32'd0);
`ifdef FIFO_MULTI_CH_RING_ERR_EN
        check("rst_ovf", 32'(a_ovf), 32'd0);
        check("rst_udf", 32'(a_udf), 32'd0);
`endif
        step();
        check("rst_nowrite", 32'(a_empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
